ws_array_controller: RTL and testbench

Sequencing controller for an ARRAY_SIZE × ARRAY_SIZE weight-stationary systolic array built from ProcessingElementWS tiles. On a start request it loads one weight tile into the array (mode 0), streams a configured number of activation vectors with per-row skewed enables (mode 1), drains the pipeline and reports completion. It sits between the tile scheduler (start/done, weight SRAM, activation stream) and the array's mode/enable/weight-shift inputs.

---
 rtl/ws_array_controller_if.sv | 40 ++++
 rtl/ws_array_controller.sv | 119 +++++++++++
 tb/tb_ws_array_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ws_array_controller_if.sv
// Scheduler/array-side signal bundle for ws_array_controller.
// stall_count exists only when WS_CTRL_PERF_EN is defined.
interface ws_array_controller_if #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned VECWIDTH   = 16
);
  localparam int unsigned RowW = $clog2(ARRAY_SIZE);

  logic                  start;
  logic [VECWIDTH-1:0]   cfg_num_vec;
  logic                  busy;
  logic                  done;
  logic                  w_rd_en;
  logic [RowW-1:0]       w_rd_row;
  logic                  w_shift;
  logic                  mode;
  logic                  a_valid;
  logic                  a_ready;
  logic [ARRAY_SIZE-1:0] pe_enable;
  logic [ARRAY_SIZE-1:0] ps_valid;
`ifdef WS_CTRL_PERF_EN
  logic [VECWIDTH-1:0]   stall_count;
`endif

  modport master (
    output start, cfg_num_vec, a_valid,
    input  busy, done, w_rd_en, w_rd_row, w_shift, mode, a_ready, pe_enable, ps_valid
`ifdef WS_CTRL_PERF_EN
    , input stall_count
`endif
  );

  modport slave (
    input  start, cfg_num_vec, a_valid,
    output busy, done, w_rd_en, w_rd_row, w_shift, mode, a_ready, pe_enable, ps_valid
`ifdef WS_CTRL_PERF_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/ws_array_controller.sv
// Weight-stationary systolic array sequencer: weight load, skewed compute, drain, done.
// Define WS_CTRL_PERF_EN to add the saturating stall_count performance counter.
module ws_array_controller #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned VECWIDTH   = 16
) (
  input logic                  clk,
  input logic                  reset,
  ws_array_controller_if.slave bus
);
  localparam int unsigned RowW   = $clog2(ARRAY_SIZE);
  localparam int unsigned DrainW = $clog2(2 * ARRAY_SIZE);
  // Deepest tap is ps_valid[ARRAY_SIZE-1] at 2*ARRAY_SIZE-1 cycles of delay.
  localparam int unsigned SkewW  = 2 * ARRAY_SIZE - 1;

  typedef enum logic [2:0] {StIdle, StLoadW, StCompute, StDrain, StDone} state_e;

  state_e              state_q;
  logic [VECWIDTH-1:0] count_q;
  logic [RowW-1:0]     row_q;
  logic                rd_en_q;
  logic                shift_q;
  logic [DrainW-1:0]   drain_q;
  logic [SkewW-1:0]    skew_q;
  logic                issue;

  assign issue = (state_q == StCompute) && bus.a_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      row_q   <= '0;
      rd_en_q <= 1'b0;
      shift_q <= 1'b0;
      drain_q <= '0;
      skew_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StLoadW;
            count_q <= bus.cfg_num_vec;
            row_q   <= RowW'(ARRAY_SIZE - 1);
            rd_en_q <= 1'b1;
          end
        end
        StLoadW: begin
          shift_q <= rd_en_q;
          if (rd_en_q) begin
            if (row_q == '0) rd_en_q <= 1'b0;
            else             row_q   <= row_q - RowW'(1);
          end
          // Last shift cycle: read strobe already dropped, shift still high.
          if (shift_q && !rd_en_q) begin
            state_q <= (count_q != '0) ? StCompute : StDone;
          end
        end
        StCompute: begin
          if (issue && (count_q != '0)) begin
            count_q <= count_q - VECWIDTH'(1);
            if (count_q == VECWIDTH'(1)) begin
              state_q <= StDrain;
              drain_q <= DrainW'(2 * ARRAY_SIZE - 2);
            end
          end
        end
        StDrain: begin
          if (drain_q == '0) state_q <= StDone;
          else               drain_q <= drain_q - DrainW'(1);
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if ((state_q == StCompute) || (state_q == StDrain)) begin
        skew_q <= {skew_q[SkewW-2:0], issue};
      end else begin
        skew_q <= '0;
      end
    end
  end

`ifdef WS_CTRL_PERF_EN
  logic [VECWIDTH-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == StIdle) && bus.start) begin
      stall_q <= '0;
    end else if ((state_q == StCompute) && !bus.a_valid && (stall_q != '1)) begin
      stall_q <= stall_q + VECWIDTH'(1);
    end
  end

  assign bus.stall_count = stall_q;
`endif

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.mode     = (state_q == StCompute) || (state_q == StDrain);
  assign bus.a_ready  = (state_q == StCompute);
  assign bus.w_rd_en  = rd_en_q;
  assign bus.w_rd_row = row_q;
  assign bus.w_shift  = shift_q;

  always_comb begin
    bus.pe_enable    = '0;
    bus.ps_valid     = '0;
    bus.pe_enable[0] = issue;
    for (int r = 1; r < ARRAY_SIZE; r++) begin
      bus.pe_enable[r] = skew_q[r-1];
    end
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      bus.ps_valid[c] = skew_q[ARRAY_SIZE+c-1];
    end
  end
endmodule

// File: tb/tb_ws_array_controller.sv
// Self-checking bench for ws_array_controller: timeline model plus directed literal checks.
module tb_ws_array_controller;
  localparam int unsigned N      = 4;
  localparam int unsigned VW     = 16;
  localparam int          MaxCyc = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ws_array_controller_if #(.ARRAY_SIZE(N), .VECWIDTH(VW)) bus ();

  ws_array_controller #(.ARRAY_SIZE(N), .VECWIDTH(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a job is described by its accept cycle, remaining count and the cycles it issued on.
  bit             m_on = 1'b0;
  bit             m_job = 1'b0;
  int             m_s, m_rem, m_done_at;
  logic [VW-1:0]  m_stall = '0;
  bit             issued [MaxCyc];

  // Observed history, used by the literal checks.
  bit pe0_h [MaxCyc];
  bit pe2_h [MaxCyc];
  bit done_h [MaxCyc];
  bit busy_h [MaxCyc];
  bit shift_h [MaxCyc];
  bit ready_h [MaxCyc];
  bit ps3_h [MaxCyc];
  int row_h [MaxCyc];
  bit ps_any_h [MaxCyc];

  bit           ld, cp, dr, dn, iss;
  int           row;
  logic [N-1:0] e_pe, e_ps;

  always @(negedge clk) begin
    ld  = m_job && (cyc <= m_s + N + 1);
    cp  = m_job && !ld && (m_rem > 0);
    dn  = m_job && (cyc == m_done_at);
    dr  = m_job && !ld && !cp && !dn;
    iss = cp && bus.a_valid;
    row = (ld && cyc <= m_s + N) ? (N - 1 - (cyc - m_s - 1)) : 0;
    for (int r = 0; r < N; r++) begin
      if (r == 0) e_pe[r] = iss;
      else        e_pe[r] = (cyc - r >= 0) ? issued[cyc-r] : 1'b0;
      e_ps[r] = (cyc - int'(N) - r >= 0) ? issued[cyc-int'(N)-r] : 1'b0;
    end

    if (m_on) begin
      chk("busy", 32'(bus.busy), 32'(m_job));
      chk("done", 32'(bus.done), 32'(dn));
      chk("w_rd_en", 32'(bus.w_rd_en), 32'(ld && cyc <= m_s + N));
      chk("w_rd_row", 32'(bus.w_rd_row), 32'(row));
      chk("w_shift", 32'(bus.w_shift), 32'(ld && cyc >= m_s + 2));
      if (!dn) chk("mode", 32'(bus.mode), 32'(cp || dr));
      chk("a_ready", 32'(bus.a_ready), 32'(cp));
      chk("pe_enable", 32'(bus.pe_enable), 32'(e_pe));
      chk("ps_valid", 32'(bus.ps_valid), 32'(e_ps));
`ifdef WS_CTRL_PERF_EN
      chk("stall_count", 32'(bus.stall_count), 32'(m_stall));
`endif
    end

    if (cyc < MaxCyc) begin
      pe0_h[cyc]    = bus.pe_enable[0];
      pe2_h[cyc]    = bus.pe_enable[2];
      done_h[cyc]   = bus.done;
      busy_h[cyc]   = bus.busy;
      shift_h[cyc]  = bus.w_shift;
      ready_h[cyc]  = bus.a_ready;
      ps3_h[cyc]    = bus.ps_valid[N-1];
      ps_any_h[cyc] = |bus.ps_valid;
      row_h[cyc]    = int'(bus.w_rd_row);
    end

    if (reset) begin
      m_on    = 1'b1;
      m_job   = 1'b0;
      m_stall = '0;
      for (int i = 0; i < MaxCyc; i++) issued[i] = 1'b0;
    end else if (m_on) begin
      if (m_job) begin
        if (iss) begin
          issued[cyc] = 1'b1;
          m_rem--;
          if (m_rem == 0) m_done_at = cyc + 2 * N;
        end
        if (cp && !bus.a_valid && m_stall != '1) m_stall++;
        if (dn) m_job = 1'b0;
      end else if (bus.start) begin
        m_job     = 1'b1;
        m_s       = cyc;
        m_rem     = int'(bus.cfg_num_vec);
        m_done_at = (bus.cfg_num_vec == '0) ? cyc + N + 2 : -1;
        m_stall   = '0;
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input int nv, output int s);
    bus.start       = 1'b1;
    bus.cfg_num_vec = VW'(nv);
    s               = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        when = cyc;
        break;
      end
    end
    chk(name, 32'(when >= 0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  int s, t, n;

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.cfg_num_vec = '0;
    bus.a_valid     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    goto(cyc + 3);
    chk("idle_busy", 32'(busy_h[cyc-1]), 32'd0);

    // Job 1: three vectors, a_valid steady.
    bus.a_valid = 1'b1;
    launch(3, s);
    wait_done("job1_done", 40, t);
    chk("job1_done_cycle", 32'(t - s), 32'd16);
    chk("job1_row_first", 32'(row_h[s+1]), 32'd3);
    chk("job1_row_last", 32'(row_h[s+4]), 32'd0);
    chk("job1_shift_first", 32'({shift_h[s+1], shift_h[s+2]}), 32'b01);
    chk("job1_shift_last", 32'({shift_h[s+5], shift_h[s+6]}), 32'b10);
    chk("job1_ready_first", 32'({ready_h[s+5], ready_h[s+6]}), 32'b01);
    chk("job1_issues", 32'({pe0_h[s+6], pe0_h[s+7], pe0_h[s+8], pe0_h[s+9]}), 32'b1110);
    chk("job1_ps3_last", 32'({ps3_h[s+15], ps3_h[s+16]}), 32'b10);

    // Job 2: two vectors with one bubble.
    bus.a_valid = 1'b0;
    goto(cyc + 2);
    launch(2, s);
    goto(s + 6); bus.a_valid = 1'b1;
    goto(s + 7); bus.a_valid = 1'b0;
    goto(s + 8); bus.a_valid = 1'b1;
    goto(s + 9); bus.a_valid = 1'b0;
    wait_done("job2_done", 40, t);
    chk("job2_done_cycle", 32'(t - s), 32'd16);
    chk("job2_pe0", 32'({pe0_h[s+6], pe0_h[s+7], pe0_h[s+8]}), 32'b101);
    chk("job2_pe2", 32'({pe2_h[s+8], pe2_h[s+9], pe2_h[s+10]}), 32'b101);
`ifdef WS_CTRL_PERF_EN
    chk("job2_stall_count", 32'(bus.stall_count), 32'd1);
`endif

    // Job 3: zero vectors goes straight from weight load to done.
    goto(cyc + 2);
    launch(0, s);
    wait_done("job3_done", 20, t);
    chk("job3_done_cycle", 32'(t - s), 32'd6);
    n = 0;
    for (int i = s; i <= t; i++) n += int'(ready_h[i]) + int'(ps_any_h[i]);
    chk("job3_no_ready_no_ps", 32'(n), 32'd0);

    // Job 4: start during COMPUTE and in the DONE cycle must be ignored.
    bus.a_valid = 1'b1;
    goto(cyc + 2);
    launch(3, s);
    goto(s + 7);  bus.start = 1'b1; bus.cfg_num_vec = VW'(9);
    goto(s + 8);  bus.start = 1'b0;
    goto(s + 16); bus.start = 1'b1; bus.cfg_num_vec = VW'(5);
    goto(s + 17); bus.start = 1'b0;
    goto(s + 20);
    chk("job4_done_cycle", 32'({done_h[s+15], done_h[s+16], done_h[s+17]}), 32'b010);
    chk("job4_idle_after", 32'({busy_h[s+17], busy_h[s+18], busy_h[s+19]}), 32'b000);

    // Job 5: reset after the first issue aborts the job.
    goto(cyc + 2);
    launch(5, s);
    goto(s + 7); bus.a_valid = 1'b0; reset = 1'b1;
    goto(s + 8); reset = 1'b0;
    goto(s + 30);
    chk("job5_issue", 32'({pe0_h[s+6], pe0_h[s+7]}), 32'b10);
    chk("job5_idle", 32'(busy_h[s+8]), 32'd0);
    n = 0;
    for (int i = s + 7; i < s + 30; i++) n += int'(done_h[i]);
    chk("job5_no_done", 32'(n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
